// File: rtl/audio_mixer_pkg.sv
// rtl/audio_mixer_pkg.sv - shared types, widths and the 16-bit clamp for the stereo mixer
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    MIX_NONE = 2'd0,
    MIX_X8   = 2'd1,
    MIX_X4   = 2'd2,
    MIX_MONO = 2'd3
  } mix_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_MIX   = 2'd2,
    ST_OUT   = 2'd3
  } mixer_state_t;

  localparam int ATT_W = 4;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return 16'(v);
  endfunction

endpackage

// File: rtl/audio_fade_ramp.sv
// rtl/audio_fade_ramp.sv - master gain ramp, one step toward the mute target per advance strobe
module audio_fade_ramp #(
  parameter int FADE_BITS = 6
) (
  input  logic                 clk_audio,
  input  logic                 reset,
  input  logic                 advance,
  input  logic                 master_mute,
  output logic [FADE_BITS:0]   gain
);

  localparam logic [FADE_BITS:0] GAIN_FULL = {1'b1, {FADE_BITS{1'b0}}};
  localparam logic [FADE_BITS:0] GAIN_ONE  = {{FADE_BITS{1'b0}}, 1'b1};

  // Direction is re-evaluated every step, so toggling the mute mid-ramp reverses from the current gain.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      gain <= '0;
    end else if (advance) begin
      if (master_mute) begin
        if (gain != '0)
          gain <= gain - GAIN_ONE;
      end else begin
        if (gain != GAIN_FULL)
          gain <= gain + GAIN_ONE;
      end
    end
  end

endmodule

// File: rtl/audio_mixer_mc.sv
// rtl/audio_mixer_mc.sv - N-channel stereo mixer with time-multiplexed accumulation, crossfeed and fade
module audio_mixer_mc
  import audio_mixer_pkg::*;
#(
  parameter int DW        = 16,
  parameter int NUM_CH    = 4,
  parameter int FADE_BITS = 6
) (
  input  logic                      clk_audio,
  input  logic                      reset,
  input  logic                      sample_stb,
  input  logic                      is_signed,
  input  logic [NUM_CH*DW-1:0]      ch_l,
  input  logic [NUM_CH*DW-1:0]      ch_r,
  input  logic [NUM_CH*ATT_W-1:0]   ch_att,
  input  logic [NUM_CH-1:0]         ch_mute,
  input  logic [1:0]                mix,
  input  logic                      master_mute,
  output logic signed [15:0]        out_l,
  output logic signed [15:0]        out_r,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = 16 + $clog2(NUM_CH) + 1;
  localparam int PROD_W = 16 + FADE_BITS + 2;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] IDX_ONE  = {{(CH_W-1){1'b0}}, 1'b1};

  mixer_state_t              state;
  logic [CH_W-1:0]           idx;
  logic [NUM_CH*DW-1:0]      snap_l;
  logic [NUM_CH*DW-1:0]      snap_r;
  logic [NUM_CH*ATT_W-1:0]   snap_att;
  logic [NUM_CH-1:0]         snap_mute;
  logic                      snap_signed;
  mix_mode_t                 snap_mix;
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [15:0]        mixed_l;
  logic signed [15:0]        mixed_r;
  logic signed [15:0]        scaled_l;
  logic signed [15:0]        scaled_r;
  logic                      out_pend;
  logic [FADE_BITS:0]        gain;

  // Left-justify, convert offset binary to two's complement, attenuate, then gate by mute.
  function automatic logic signed [15:0] chan_term(
    input logic [DW-1:0]    s,
    input logic [ATT_W-1:0] att,
    input logic             mute,
    input logic             sgn
  );
    logic [15:0] p;
    p = '0;
    p[15 -: DW] = s;
    if (!sgn)
      p[15] = ~p[15];
    if (mute)
      return '0;
    return $signed(p) >>> att;
  endfunction

  logic signed [15:0] term_l, term_r;
  always_comb begin
    term_l = chan_term(snap_l[idx*DW +: DW], snap_att[idx*ATT_W +: ATT_W], snap_mute[idx], snap_signed);
    term_r = chan_term(snap_r[idx*DW +: DW], snap_att[idx*ATT_W +: ATT_W], snap_mute[idx], snap_signed);
  end

  logic signed [15:0] sat_l, sat_r, mix_l, mix_r;
  logic signed [17:0] sl_w, sr_w, diff, diff_q, mono;
  always_comb begin
    sat_l  = sat16(32'(acc_l));
    sat_r  = sat16(32'(acc_r));
    sl_w   = 18'(sat_l);
    sr_w   = 18'(sat_r);
    diff   = sr_w - sl_w;
    mono   = (sl_w + sr_w) >>> 1;
    diff_q = (snap_mix == MIX_X4) ? (diff >>> 2) : (diff >>> 3);
    mix_l  = sat_l;
    mix_r  = sat_r;
    case (snap_mix)
      MIX_X8, MIX_X4: begin
        mix_l = 16'(sl_w + diff_q);
        mix_r = 16'(sr_w - diff_q);
      end
      MIX_MONO: begin
        mix_l = 16'(mono);
        mix_r = 16'(mono);
      end
      default: ;
    endcase
  end

  logic signed [PROD_W-1:0] gain_s, prod_l, prod_r;
  always_comb begin
    gain_s = PROD_W'($signed({1'b0, gain}));
    prod_l = PROD_W'(mixed_l) * gain_s;
    prod_r = PROD_W'(mixed_r) * gain_s;
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      snap_l      <= '0;
      snap_r      <= '0;
      snap_att    <= '0;
      snap_mute   <= '0;
      snap_signed <= 1'b0;
      snap_mix    <= MIX_NONE;
      acc_l       <= '0;
      acc_r       <= '0;
      mixed_l     <= '0;
      mixed_r     <= '0;
      scaled_l    <= '0;
      scaled_r    <= '0;
      out_pend    <= 1'b0;
      out_l       <= '0;
      out_r       <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= out_pend;
      out_pend  <= 1'b0;
      overrun   <= sample_stb && (state != ST_IDLE);
      if (out_pend) begin
        out_l <= scaled_l;
        out_r <= scaled_r;
      end
      case (state)
        ST_IDLE: begin
          if (sample_stb) begin
            snap_l      <= ch_l;
            snap_r      <= ch_r;
            snap_att    <= ch_att;
            snap_mute   <= ch_mute;
            snap_signed <= is_signed;
            snap_mix    <= mix_mode_t'(mix);
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            state       <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_l <= acc_l + ACC_W'(term_l);
          acc_r <= acc_r + ACC_W'(term_r);
          if (idx == LAST_IDX)
            state <= ST_MIX;
          else
            idx <= idx + IDX_ONE;
        end
        ST_MIX: begin
          mixed_l <= mix_l;
          mixed_r <= mix_r;
          state   <= ST_OUT;
        end
        ST_OUT: begin
          scaled_l <= 16'(prod_l >>> FADE_BITS);
          scaled_r <= 16'(prod_r >>> FADE_BITS);
          out_pend <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // Gain steps after the OUT cycle has consumed it, so the new value applies to the next sample.
  audio_fade_ramp #(
    .FADE_BITS (FADE_BITS)
  ) u_fade (
    .clk_audio   (clk_audio),
    .reset       (reset),
    .advance     (state == ST_OUT),
    .master_mute (master_mute),
    .gain        (gain)
  );

endmodule

// File: tb/tb_audio_mixer_mc.sv
// tb/tb_audio_mixer_mc.sv - directed self-checking bench for audio_mixer_mc
module tb_audio_mixer_mc;

  logic        clk_audio;
  logic        reset;
  logic        sample_stb;
  logic        is_signed;
  logic [63:0] ch_l;
  logic [63:0] ch_r;
  logic [15:0] ch_att;
  logic [3:0]  ch_mute;
  logic [1:0]  mix;
  logic        master_mute;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  audio_mixer_mc #(.DW(16), .NUM_CH(4), .FADE_BITS(6)) dut (
    .clk_audio   (clk_audio),
    .reset       (reset),
    .sample_stb  (sample_stb),
    .is_signed   (is_signed),
    .ch_l        (ch_l),
    .ch_r        (ch_r),
    .ch_att      (ch_att),
    .ch_mute     (ch_mute),
    .mix         (mix),
    .master_mute (master_mute),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_sample(output logic [15:0] l, output logic [15:0] r, output int lat);
    @(negedge clk_audio);
    sample_stb = 1'b1;
    @(posedge clk_audio);
    #1;
    sample_stb = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk_audio);
      #1;
      lat++;
    end
    l = out_l;
    r = out_r;
  endtask

  task automatic pair_strobe(input int gap, output int nv, output int no);
    @(negedge clk_audio);
    sample_stb = 1'b1;
    nv = 0;
    no = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk_audio);
      #1;
      sample_stb = (c == gap - 1);
      nv += int'(out_valid);
      no += int'(overrun);
    end
  endtask

  task automatic set_ch0(input logic [15:0] l0, input logic [15:0] r0);
    ch_l = {48'h0, l0};
    ch_r = {48'h0, r0};
    ch_att = '0;
    ch_mute = '0;
    is_signed = 1'b1;
    mix = 2'd0;
  endtask

  logic [15:0] l, r;
  int lat, nv, no, expg;

  initial begin
    reset = 1'b1;
    sample_stb = 1'b0;
    master_mute = 1'b0;
    set_ch0(16'h0000, 16'h0000);
    repeat (3) @(posedge clk_audio);
    #1;
    check("rst_out_l", 32'(out_l), 32'h0);
    check("rst_out_r", 32'(out_r), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;

    // Ramp up from silence: sample k uses gain min(k,64).
    set_ch0(16'h4000, 16'h0000);
    for (int k = 0; k < 66; k++) begin
      run_sample(l, r, lat);
      expg = (k < 64) ? k : 64;
      check($sformatf("ramp_l_%0d", k), 32'(l), 32'(expg * 256));
      check($sformatf("ramp_r_%0d", k), 32'(r), 32'h0);
      if (k == 0) check("ramp_lat", 32'(lat), 32'd7);
    end

    ch_l = {4{16'h7000}};
    run_sample(l, r, lat);
    check("sat_pos", 32'(l), 32'h7fff);
    check("sat_pos_lat", 32'(lat), 32'd7);
    ch_l = {4{16'h9000}};
    run_sample(l, r, lat);
    check("sat_neg", 32'(l), 32'h8000);
    check("sat_neg_lat", 32'(lat), 32'd7);

    ch_l = {16'h8000, 16'h8000, 16'h8000, 16'hC000};
    ch_r = {4{16'h8000}};
    ch_att = '0;
    ch_mute = '0;
    is_signed = 1'b0;
    run_sample(l, r, lat);
    check("ofs_att0", 32'(l), 32'h4000);
    check("ofs_r", 32'(r), 32'h0);
    ch_att = 16'h0002;
    run_sample(l, r, lat);
    check("ofs_att2", 32'(l), 32'h1000);
    ch_mute = 4'b0001;
    run_sample(l, r, lat);
    check("ofs_mute", 32'(l), 32'h0);

    set_ch0(16'h4000, 16'h0000);
    for (int m = 0; m < 4; m++) begin
      mix = 2'(m);
      run_sample(l, r, lat);
      case (m)
        0: begin check("mix0_l", 32'(l), 32'h4000); check("mix0_r", 32'(r), 32'h0000); end
        1: begin check("mix1_l", 32'(l), 32'h3800); check("mix1_r", 32'(r), 32'h0800); end
        2: begin check("mix2_l", 32'(l), 32'h3000); check("mix2_r", 32'(r), 32'h1000); end
        default: begin check("mix3_l", 32'(l), 32'h2000); check("mix3_r", 32'(r), 32'h2000); end
      endcase
    end
    mix = 2'd0;

    pair_strobe(3, nv, no);
    check("gap3_valid", 32'(nv), 32'd1);
    check("gap3_overrun", 32'(no), 32'd1);
    pair_strobe(6, nv, no);
    check("gap6_valid", 32'(nv), 32'd1);
    check("gap6_overrun", 32'(no), 32'd1);
    pair_strobe(7, nv, no);
    check("gap7_valid", 32'(nv), 32'd2);
    check("gap7_overrun", 32'(no), 32'd0);

    // Fade down to gain 32, reverse for two samples, then fade all the way to silence.
    master_mute = 1'b1;
    for (int k = 0; k < 32; k++) begin
      run_sample(l, r, lat);
      check($sformatf("fade_dn_%0d", k), 32'(l), 32'((64 - k) * 256));
    end
    master_mute = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_sample(l, r, lat);
      check($sformatf("fade_rev_%0d", k), 32'(l), 32'((32 + k) * 256));
    end
    master_mute = 1'b1;
    for (int k = 0; k < 36; k++) begin
      run_sample(l, r, lat);
      expg = (k < 34) ? (34 - k) : 0;
      check($sformatf("fade_zero_%0d", k), 32'(l), 32'(expg * 256));
    end

    master_mute = 1'b0;
    for (int k = 0; k < 3; k++) run_sample(l, r, lat);
    check("pre_rst_l", 32'(l), 32'h0200);

    @(negedge clk_audio);
    sample_stb = 1'b1;
    @(posedge clk_audio);
    #1;
    sample_stb = 1'b0;
    repeat (2) begin
      @(posedge clk_audio);
      #1;
    end
    check("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk_audio);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_out_l", 32'(out_l), 32'h0);
    check("abort_out_r", 32'(out_r), 32'h0);
    check("abort_valid", 32'(out_valid), 32'h0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_audio);
      #1;
      nv += int'(out_valid);
    end
    check("abort_no_valid", 32'(nv), 32'd0);
    run_sample(l, r, lat);
    check("post_rst_gain0", 32'(l), 32'h0000);
    check("post_rst_lat", 32'(lat), 32'd7);
    run_sample(l, r, lat);
    check("post_rst_gain1", 32'(l), 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_mixer_mc.md
Name: audio_mixer_mc

Overview:
Parametrised N-channel stereo mixer. It runs in the audio clock domain ahead of the audio filter / I2S stage. On each sample strobe it snapshots all channels and sums them through a time-multiplexed accumulator, one channel per cycle. It applies per-channel attenuation and mute, saturation, an L/R crossfeed mode, and a pop-free master mute fade ramp, then emits one 16-bit stereo sample with a valid pulse.

Parameters:
DW, 16, per-channel sample width (1..16); samples are left-justified to 16 bits by zero padding.
NUM_CH, 4, number of stereo input channels (1..16).
FADE_BITS, 6, fade ramp resolution; full gain = 2^FADE_BITS, ramp length = 2^FADE_BITS samples.

Ports:
clk_audio  in  1  audio clock; single clock domain.
reset  in  1  synchronous, active-high reset.
sample_stb  in  1  one-cycle strobe requesting one output sample.
is_signed  in  1  1 = inputs are two's complement; 0 = offset binary.
ch_l  in  NUM_CH*DW  left samples; channel i at [i*DW +: DW].
ch_r  in  NUM_CH*DW  right samples, same packing.
ch_att  in  NUM_CH*4  per-channel arithmetic right shift 0..15.
ch_mute  in  NUM_CH  per-channel mute.
mix  in  2  0 none | 1 1/8 crossfeed | 2 1/4 crossfeed | 3 mono.
master_mute  in  1  fade target: 1 = silence, 0 = full gain.
out_l  out  16  signed left output.
out_r  out  16  signed right output.
out_valid  out  1  one-cycle pulse when out_l/out_r update.
busy  out  1  high in any state except IDLE.
overrun  out  1  one-cycle pulse when sample_stb is dropped.

Behaviour:
- Reset: out_l = out_r = 0; out_valid = busy = overrun = 0; state = IDLE; fade gain = 0. After reset the output ramps up from silence.
- Reset mid-operation aborts the sample. No out_valid is issued for it, and all state returns to reset values on the next edge.
- FSM states: IDLE -> ACCUM -> MIX -> OUT -> IDLE.
- IDLE: on sample_stb, snapshot ch_l, ch_r, ch_att, ch_mute, is_signed and mix. Then clear acc_l/acc_r, set idx = 0 and go to ACCUM.
- ACCUM runs one cycle per channel, for idx = 0..NUM_CH-1:
  - Pad the sample to 16 bits.
  - If !is_signed, invert the MSB.
  - Arithmetic-shift right by att.
  - Contribute 0 if muted.
  - Add to the accumulator. Accumulator width is 16 + clog2(NUM_CH) + 1, so no accumulator overflow is possible.
  - After idx = NUM_CH-1, go to MIX.
- MIX: saturate each accumulator to [-32768, 32767], giving sL/sR. Then apply the mix mode, with d = sR - sL in 17-bit arithmetic:
  - mode 0: L = sL, R = sR.
  - mode 1: L = sL + (d>>>3), R = sR - (d>>>3).
  - mode 2: L = sL + (d>>>2), R = sR - (d>>>2).
  - mode 3: L = R = (sL + sR)>>>1.
  - Results are convex combinations, so no overflow. Go to OUT.
- OUT: out = (mixed * gain) >>> FADE_BITS in widened signed arithmetic.
  - Register out_l/out_r and assert out_valid on the following cycle.
  - Step gain by 1 toward target (0 when master_mute, else 2^FADE_BITS) after use, i.e. once per output sample.
  - Gain saturates at both ends. The new gain applies to the next sample.
  - Return to IDLE.
- Latency: out_valid is high NUM_CH+3 edges after the edge that samples sample_stb. Minimum strobe spacing is NUM_CH+3 cycles.
- sample_stb while busy: the strobe is ignored and overrun pulses for one cycle. The in-flight sample completes unaffected.
- A strobe arriving in the same cycle the FSM returns to IDLE (OUT -> IDLE edge) is treated as busy and dropped.
- master_mute toggling mid-ramp reverses direction from the current gain. No jump is permitted.
- Inputs may change freely while busy; only the snapshot is used.

Decomposition:
- Package audio_mixer_pkg:
  - mix_mode_t enum (MIX_NONE, MIX_X8, MIX_X4, MIX_MONO).
  - mixer_state_t enum.
  - ATT_W = 4.
  - sat16 function (signed wide to 16-bit clamp).
- Sub-module audio_fade_ramp: gain register, target select, step on an advance strobe, reset to 0. This isolates the ramp for reuse on other output paths.

Test Plan:
1. NUM_CH=4, DW=16, FADE_BITS=6, reset then master_mute=0, ch0 L=0x4000 att 0, others 0, strobe every 16 cycles -> 1st out_l=0x0000, 2nd 0x0100, increasing 0x0100 per sample; from the 65th sample holds 0x4000; out_r=0 throughout.
2. At full gain: all four L=0x7000 -> out_l=0x7FFF; all four L=0x9000 -> out_l=0x8000; out_valid exactly 7 edges after each strobe.
3. is_signed=0, ch0 L=0xC000, att 0 -> 0x4000; att=2 -> 0x1000; ch_mute[0]=1 -> 0x0000.
4. Single channel sL=0x4000, sR=0: mix0 -> (0x4000, 0x0000); mix1 -> (0x3800, 0x0800); mix2 -> (0x3000, 0x1000); mix3 -> (0x2000, 0x2000).
5. Strobes 3 cycles apart -> second dropped, overrun pulses once, exactly one out_valid. Then master_mute=1 from full gain -> output reaches 0 after 64 samples; clearing it at gain 32 ramps back up from 32.
6. Assert reset during ACCUM (idx=2) -> next edge: busy=0, out_l/out_r=0, no out_valid, gain=0; a subsequent strobe produces a normal sample at gain 0.
